// File: rtl/count_timer_ctrl.sv
// Run/pause/alarm sequencer for the BCD counter: debounced buttons, tick prescaler, clear/load/step pulses.
// Press reaches the FSM 3 cycles after the raw edge; all outputs registered (one cycle after cause); no backpressure.
module count_timer_ctrl #(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned ALARM_TICKS  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_n,
    input  logic        stop_n,
    input  logic        mode_down,
    input  logic        fast,
    input  logic [15:0] preset,
    input  logic        cnt_zero,
    input  logic        cnt_max,
    output logic        cnt_clr,
    output logic        cnt_load,
    output logic [15:0] cnt_load_val,
    output logic        cnt_en,
    output logic        cnt_down,
    output logic        alarm,
    output logic [1:0]  state
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int DW = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int AW = $clog2(ALARM_TICKS + 1);

    localparam logic [PW-1:0] LIM_NORM = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] LIM_FAST = PW'(TICK_DIV / 2 - 1);
    localparam logic [DW-1:0] DB_LOAD  = DW'(DEBOUNCE_CYC);
    localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync1_q, sync2_q, sync3_q;
    logic [DW-1:0] start_db_q, start_db_d, stop_db_q, stop_db_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [AW-1:0] alm_cnt_q, alm_cnt_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          cnt_load_q, cnt_load_d;
    logic [15:0]   cnt_load_val_q, cnt_load_val_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_down_q, cnt_down_d;
    logic          alarm_q, alarm_d;

    logic [1:0]    press_raw;
    logic          start_press, stop_press, start_cmd, any_press;
    logic          tick, terminal, alarm_done;
    logic [PW-1:0] limit;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
        end
        return r;
    endfunction

    // Bit 0 = start, bit 1 = stop; falling edge on the synchronized level is a press.
    always_comb begin
        press_raw   = sync3_q & ~sync2_q;
        start_press = press_raw[0] && (start_db_q == '0);
        stop_press  = press_raw[1] && (stop_db_q == '0);
        start_cmd   = start_press && !stop_press;
        any_press   = start_press || stop_press;

        start_db_d = start_db_q;
        if (start_press)            start_db_d = DB_LOAD;
        else if (start_db_q != '0)  start_db_d = start_db_q - DW'(1);

        stop_db_d = stop_db_q;
        if (stop_press)             stop_db_d = DB_LOAD;
        else if (stop_db_q != '0)   stop_db_d = stop_db_q - DW'(1);
    end

    // ">=" lets a live switch to fast fire immediately when pre is already past the short limit.
    always_comb begin
        limit      = fast ? LIM_FAST : LIM_NORM;
        tick       = ((state_q == RUN) || (state_q == ALARM)) && (pre_q >= limit);
        terminal   = cnt_down_q ? cnt_zero : cnt_max;
        alarm_done = (alm_cnt_q == ALM_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sync1_q        <= 2'b11;
            sync2_q        <= 2'b11;
            sync3_q        <= 2'b11;
            start_db_q     <= '0;
            stop_db_q      <= '0;
            pre_q          <= '0;
            alm_cnt_q      <= '0;
            cnt_clr_q      <= 1'b0;
            cnt_load_q     <= 1'b0;
            cnt_load_val_q <= '0;
            cnt_en_q       <= 1'b0;
            cnt_down_q     <= 1'b0;
            alarm_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= {stop_n, start_n};
            sync2_q        <= sync1_q;
            sync3_q        <= sync2_q;
            start_db_q     <= start_db_d;
            stop_db_q      <= stop_db_d;
            pre_q          <= pre_d;
            alm_cnt_q      <= alm_cnt_d;
            cnt_clr_q      <= cnt_clr_d;
            cnt_load_q     <= cnt_load_d;
            cnt_load_val_q <= cnt_load_val_d;
            cnt_en_q       <= cnt_en_d;
            cnt_down_q     <= cnt_down_d;
            alarm_q        <= alarm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_cmd) state_d = RUN;
            RUN: begin
                if (stop_press)              state_d = IDLE;
                else if (start_cmd)          state_d = PAUSE;
                else if (tick && terminal)   state_d = ALARM;
            end
            PAUSE: begin
                if (stop_press)              state_d = IDLE;
                else if (start_cmd)          state_d = RUN;
            end
            ALARM: if (any_press || (tick && alarm_done)) state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_clr_d      = 1'b0;
        cnt_load_d     = 1'b0;
        cnt_en_d       = 1'b0;
        cnt_down_d     = cnt_down_q;
        cnt_load_val_d = cnt_load_val_q;
        alarm_d        = alarm_q;
        alm_cnt_d      = alm_cnt_q;
        pre_d          = pre_q;

        unique case (state_q)
            IDLE: begin
                pre_d     = '0;
                alm_cnt_d = '0;
                if (stop_press) begin
                    cnt_clr_d = 1'b1;
                end else if (start_cmd) begin
                    cnt_down_d     = mode_down;
                    cnt_load_val_d = clamp_bcd(preset);
                    cnt_load_d     = mode_down;
                    cnt_clr_d      = !mode_down;
                end
            end
            RUN: begin
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (stop_press) begin
                    cnt_clr_d = 1'b1;
                end else if (!start_cmd && tick) begin
                    if (terminal) begin
                        alarm_d   = 1'b1;
                        alm_cnt_d = '0;
                    end else begin
                        cnt_en_d = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (stop_press) cnt_clr_d = 1'b1;
            end
            ALARM: begin
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (any_press || (tick && alarm_done)) begin
                    cnt_clr_d = 1'b1;
                    alarm_d   = 1'b0;
                    alm_cnt_d = '0;
                end else if (tick) begin
                    alarm_d   = !alarm_q;
                    alm_cnt_d = alm_cnt_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    assign cnt_clr      = cnt_clr_q;
    assign cnt_load     = cnt_load_q;
    assign cnt_load_val = cnt_load_val_q;
    assign cnt_en       = cnt_en_q;
    assign cnt_down     = cnt_down_q;
    assign alarm        = alarm_q;
    assign state        = state_q;

endmodule

// File: tb/tb_count_timer_ctrl.sv
// Directed bench for count_timer_ctrl with TICK_DIV=4, DEBOUNCE_CYC=2, ALARM_TICKS=3.
module tb_count_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start_n, stop_n, mode_down, fast, cnt_zero, cnt_max;
    logic [15:0] preset;
    logic        cnt_clr, cnt_load, cnt_en, cnt_down, alarm;
    logic [15:0] cnt_load_val;
    logic [1:0]  state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic en_seen;

    count_timer_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYC(2), .ALARM_TICKS(3)) dut (
        .clk(clk), .rst_n(rst_n), .start_n(start_n), .stop_n(stop_n),
        .mode_down(mode_down), .fast(fast), .preset(preset),
        .cnt_zero(cnt_zero), .cnt_max(cnt_max),
        .cnt_clr(cnt_clr), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
        .cnt_en(cnt_en), .cnt_down(cnt_down), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raw low for one cycle; returns just after the edge on which the FSM acts.
    task automatic press(input logic do_start, input logic do_stop);
        start_n = !do_start;
        stop_n  = !do_stop;
        step(1);
        start_n = 1'b1;
        stop_n  = 1'b1;
        step(2);
    endtask

    initial begin
        rst_n = 1'b0; start_n = 1'b1; stop_n = 1'b1; mode_down = 1'b0; fast = 1'b0;
        preset = 16'h0000; cnt_zero = 1'b0; cnt_max = 1'b0;
        step(2);
        chk("rst_state", state, 0);
        chk("rst_clr", cnt_clr, 0);
        chk("rst_load", cnt_load, 0);
        chk("rst_en", cnt_en, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_load_val", cnt_load_val, 0);
        rst_n = 1'b1;

        // Count up: clear pulse, then a step every 4 cycles.
        press(1'b1, 1'b0);
        chk("up_start_clr", cnt_clr, 1);
        chk("up_start_state", state, 1);
        chk("up_start_load", cnt_load, 0);
        chk("up_start_down", cnt_down, 0);
        step(1);
        chk("up_clr_pulse_end", cnt_clr, 0);
        step(2);
        chk("up_no_en_early", cnt_en, 0);
        step(1);
        chk("up_first_en", cnt_en, 1);
        step(1);
        chk("up_en_pulse_end", cnt_en, 0);
        step(3);
        chk("up_second_en", cnt_en, 1);

        // Live switch to fast with pre=2: fires at once, then every 2 cycles.
        step(2);
        chk("fast_pre2_no_en", cnt_en, 0);
        fast = 1'b1;
        step(1);
        chk("fast_live_tick", cnt_en, 1);
        step(1);
        chk("fast_gap", cnt_en, 0);
        step(1);
        chk("fast_en2", cnt_en, 1);
        step(1);
        chk("fast_gap2", cnt_en, 0);
        step(1);
        chk("fast_en3", cnt_en, 1);
        fast = 1'b0;

        // Pause with prescaler held at 3; resume ticks after one cycle.
        press(1'b1, 1'b0);
        chk("pause_state", state, 2);
        chk("pause_no_en_entry", cnt_en, 0);
        en_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            en_seen = en_seen | cnt_en;
        end
        chk("pause_20_no_en", en_seen, 0);
        chk("pause_held_state", state, 2);
        press(1'b1, 1'b0);
        chk("resume_state", state, 1);
        chk("resume_no_en_yet", cnt_en, 0);
        step(1);
        chk("resume_first_en", cnt_en, 1);

        // Start and stop together: stop wins.
        press(1'b1, 1'b1);
        chk("both_state", state, 0);
        chk("both_clr", cnt_clr, 1);
        step(1);
        chk("both_start_dropped", state, 0);
        chk("both_clr_end", cnt_clr, 0);

        // Start bounce inside the debounce window is ignored.
        start_n = 1'b0; step(1);
        start_n = 1'b1; step(1);
        start_n = 1'b0; step(1);
        start_n = 1'b1;
        chk("bounce_start_clr", cnt_clr, 1);
        chk("bounce_start_state", state, 1);
        step(3);
        chk("bounce_ignored", state, 1);

        press(1'b0, 1'b1);
        chk("stop_run_state", state, 0);
        chk("stop_run_clr", cnt_clr, 1);
        step(3);
        press(1'b0, 1'b1);
        chk("stop_idle_clr", cnt_clr, 1);
        chk("stop_idle_state", state, 0);

        // Count down with clamped preset, terminal at zero, alarm cycle.
        mode_down = 1'b1;
        preset = 16'h1A05;
        step(3);
        press(1'b1, 1'b0);
        chk("down_state", state, 1);
        chk("down_load", cnt_load, 1);
        chk("down_no_clr", cnt_clr, 0);
        chk("down_load_val", cnt_load_val, 32'h1905);
        chk("down_dir", cnt_down, 1);
        mode_down = 1'b0;
        step(1);
        chk("down_load_end", cnt_load, 0);
        chk("down_dir_held", cnt_down, 1);
        cnt_zero = 1'b1;
        step(2);
        chk("down_pre_terminal", state, 1);
        step(1);
        chk("alarm_state", state, 3);
        chk("alarm_on", alarm, 1);
        chk("alarm_no_en", cnt_en, 0);
        step(3);
        chk("alarm_hold", alarm, 1);
        step(1);
        chk("alarm_toggle1", alarm, 0);
        chk("alarm_toggle1_state", state, 3);
        step(4);
        chk("alarm_toggle2", alarm, 1);
        step(4);
        chk("alarm_exit_state", state, 0);
        chk("alarm_exit_alarm", alarm, 0);
        chk("alarm_exit_clr", cnt_clr, 1);

        // Reset while in ALARM with pre=2.
        mode_down = 1'b1;
        preset = 16'hC0F7;
        press(1'b1, 1'b0);
        chk("clamp_load_val", cnt_load_val, 32'h9097);
        chk("clamp_load", cnt_load, 1);
        step(4);
        chk("alarm2_state", state, 3);
        step(2);
        rst_n = 1'b0;
        step(1);
        chk("midrst_state", state, 0);
        chk("midrst_alarm", alarm, 0);
        chk("midrst_clr", cnt_clr, 0);
        chk("midrst_load", cnt_load, 0);
        chk("midrst_en", cnt_en, 0);
        chk("midrst_down", cnt_down, 0);
        chk("midrst_load_val", cnt_load_val, 0);
        rst_n = 1'b1;
        cnt_zero = 1'b0;
        mode_down = 1'b0;

        press(1'b1, 1'b0);
        chk("post_rst_clr", cnt_clr, 1);
        step(4);
        chk("post_rst_first_en", cnt_en, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
